// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler - round-robin scheduler sharing one UART Sender between two byte FIFOs. Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] REQ0_DATA,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ1_DATA,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_EN,
  input  logic       TX_STATUS,
  output logic       GRANT,
  output logic       BUSY,
  output logic       TX_TIMEOUT
);

  localparam int       c_PTR_W   = $clog2(DEPTH);
  localparam int       c_CNT_W   = c_PTR_W + 1;
  localparam bit [7:0] c_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOW  = 2'd1,
    S_WAIT_HIGH = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] tx_data_q;
  logic       tx_en_q;
  logic       grant_q;
  logic       busy_q;
  logic       timeout_q;
  logic [7:0] wait_cnt_q;

  logic [1:0][7:0] w_data;
  logic [1:0][7:0] w_head;
  logic [1:0]      w_valid;
  logic [1:0]      w_full;
  logic [1:0]      w_nonempty;
  logic [1:0]      w_pop;
  logic            w_sel;
  logic            w_issue;
  logic [7:0]      w_cnt_inc;

  assign w_data  = {REQ1_DATA, REQ0_DATA};
  assign w_valid = {REQ1_VALID, REQ0_VALID};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0]         mem_q [DEPTH];
    logic [c_PTR_W-1:0] wptr_q;
    logic [c_PTR_W-1:0] rptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic               w_push;

    // Fullness is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign w_full[gi]     = (count_q == c_CNT_W'(DEPTH));
    assign w_nonempty[gi] = (count_q != '0);
    assign w_push         = w_valid[gi] && !w_full[gi];
    assign w_pop[gi]      = w_issue && (w_sel == 1'(gi));
    assign w_head[gi]     = mem_q[rptr_q];

    always_comb begin
      count_d = count_q;
      if (w_push && !w_pop[gi]) begin
        count_d = count_q + c_CNT_W'(1);
      end else if (!w_push && w_pop[gi]) begin
        count_d = count_q - c_CNT_W'(1);
      end
    end

    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (w_push) begin
          wptr_q <= wptr_q + c_PTR_W'(1);
        end
        if (w_pop[gi]) begin
          rptr_q <= rptr_q + c_PTR_W'(1);
        end
        count_q <= count_d;
      end
    end

    always_ff @(posedge sysclk) begin
      if (w_push) begin
        mem_q[wptr_q] <= w_data[gi];
      end
    end
  end

  assign REQ0_READY = !w_full[0];
  assign REQ1_READY = !w_full[1];

  // With both queues waiting, the port that did not go last wins.
  always_comb begin
    w_sel = w_nonempty[1];
    if (w_nonempty[0] && w_nonempty[1]) begin
      w_sel = ~grant_q;
    end
  end

  assign w_issue   = (state_q == S_IDLE) && TX_STATUS && (|w_nonempty);
  assign w_cnt_inc = wait_cnt_q + 8'd1;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_issue) begin
            tx_data_q  <= w_head[w_sel];
            tx_en_q    <= 1'b1;
            grant_q    <= w_sel;
            busy_q     <= 1'b1;
            wait_cnt_q <= 8'd0;
            state_q    <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          tx_en_q <= 1'b0;
          if (!TX_STATUS) begin
            state_q <= S_WAIT_HIGH;
          end else begin
            wait_cnt_q <= w_cnt_inc;
            // An unacknowledged byte is dropped, not retried.
            if (w_cnt_inc == c_TIMEOUT) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (TX_STATUS) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          tx_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_EN      = tx_en_q;
  assign GRANT      = grant_q;
  assign BUSY       = busy_q;
  assign TX_TIMEOUT = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler - self-checking bench for uart_tx_scheduler. Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] REQ0_DATA = 8'h00;
  logic       REQ0_VALID = 1'b0;
  logic       REQ0_READY;
  logic [7:0] REQ1_DATA = 8'h00;
  logic       REQ1_VALID = 1'b0;
  logic       REQ1_READY;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       TX_STATUS = 1'b1;
  logic       GRANT;
  logic       BUSY;
  logic       TX_TIMEOUT;

  always #5 sysclk = ~sysclk;

  uart_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .REQ0_DATA (REQ0_DATA),
    .REQ0_VALID(REQ0_VALID),
    .REQ0_READY(REQ0_READY),
    .REQ1_DATA (REQ1_DATA),
    .REQ1_VALID(REQ1_VALID),
    .REQ1_READY(REQ1_READY),
    .TX_DATA   (TX_DATA),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .GRANT     (GRANT),
    .BUSY      (BUSY),
    .TX_TIMEOUT(TX_TIMEOUT)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two byte queues plus the transaction phase of the single outstanding byte.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int         m_phase;   // 0: nothing outstanding, 1: waiting for Sender to go busy, 2: waiting for idle
  int         m_age;
  logic       m_grant, m_to, m_en;
  logic [7:0] m_data;

  logic [7:0] log_d[$];
  logic       log_g[$];

  bit snd_auto = 0, snd_rand = 0, snd_pend = 0;
  int snd_wait = 0, snd_low = 0;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       st;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [13:0] ev(logic en, logic [7:0] d, logic g, logic b, logic t, logic r0, logic r1);
    return {en, d, g, b, t, r0, r1};
  endfunction

  function automatic vec_t mkv(logic v0, logic [7:0] d0, logic st, logic [13:0] e);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.st = st; v.exp = e;
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {TX_EN, TX_DATA, GRANT, BUSY, TX_TIMEOUT, REQ0_READY, REQ1_READY};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_en, m_data, m_grant, (m_phase != 0), m_to, (mq0.size() < DEPTH), (mq1.size() < DEPTH)};
  endfunction

  function automatic void model_reset();
    mq0.delete(); mq1.delete();
    m_phase = 0; m_age = 0; m_grant = 0; m_to = 0; m_en = 0; m_data = 8'h00;
    snd_pend = 0; snd_low = 0;
  endfunction

  function automatic void model_step();
    bit r0 = (mq0.size() < DEPTH);
    bit r1 = (mq1.size() < DEPTH);
    bit sel;
    m_en = 0;
    if (m_phase == 0) begin
      if (TX_STATUS && (mq0.size() != 0 || mq1.size() != 0)) begin
        if (mq0.size() != 0 && mq1.size() != 0) sel = ~m_grant;
        else sel = (mq1.size() != 0);
        m_data  = sel ? mq1.pop_front() : mq0.pop_front();
        m_en    = 1;
        m_grant = sel;
        m_age   = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!TX_STATUS) m_phase = 2;
      else begin
        m_age++;
        if (m_age == TO) begin m_to = 1; m_phase = 0; end
      end
    end else begin
      if (TX_STATUS) m_phase = 0;
    end
    if (REQ0_VALID && r0) mq0.push_back(REQ0_DATA);
    if (REQ1_VALID && r1) mq1.push_back(REQ1_DATA);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sender stand-in: goes busy some cycles after TX_EN, stays busy a while, then idles again.
  task automatic sender_update();
    if (!snd_auto) return;
    if (TX_EN === 1'b1) begin
      snd_pend = 1;
      snd_wait = !snd_rand ? 0 : (($urandom % 10 == 0) ? TO + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3)));
    end
    if (snd_pend) begin
      if (snd_wait == 0) begin
        TX_STATUS = 0;
        snd_pend  = 0;
        snd_low   = snd_rand ? int'($urandom_range(1, 6)) : 3;
      end else snd_wait--;
    end else if (TX_STATUS == 0) begin
      if (snd_low > 0) snd_low--;
      if (snd_low == 0) TX_STATUS = 1;
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
    if (TX_EN === 1'b1) begin
      log_d.push_back(TX_DATA);
      log_g.push_back(GRANT);
    end
    sender_update();
  endtask

  function automatic logic [31:0] log_at(int i);
    return (i < log_d.size()) ? {23'd0, log_g[i], log_d[i]} : 32'hxxxx_xxxx;
  endfunction

  task automatic clear_log();
    log_d.delete(); log_g.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b[5];
    logic       exp_g[4];
    int         nxt;
    logic       rdy;

    tbl[0] = mkv(1'b1, 8'h35, 1'b1, ev(0, 8'h00, 0, 0, 0, 1, 1));
    tbl[1] = mkv(1'b0, 8'h00, 1'b1, ev(1, 8'h35, 0, 1, 0, 1, 1));
    for (int i = 2; i < 12; i++) tbl[i] = mkv(1'b0, 8'h00, 1'b0, ev(0, 8'h35, 0, 1, 0, 1, 1));
    tbl[12] = mkv(1'b0, 8'h00, 1'b1, ev(0, 8'h35, 0, 0, 0, 1, 1));
    tbl[13] = mkv(1'b0, 8'h00, 1'b1, ev(0, 8'h35, 0, 0, 0, 1, 1));

    model_reset();
    repeat (2) @(negedge sysclk);
    chk("reset_values", 32'(dut_vec()), 32'(ev(0, 8'h00, 0, 0, 0, 1, 1)));
    reset = 1;

    // Single byte on port 0
    for (int i = 0; i < 14; i++) begin
      REQ0_VALID = tbl[i].v0;
      REQ0_DATA  = tbl[i].d0;
      TX_STATUS  = tbl[i].st;
      tick();
      chk($sformatf("single[%0d]", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // Round-robin with both ports preloaded
    clear_log();
    TX_STATUS = 0;
    REQ0_VALID = 1; REQ0_DATA = 8'hA0; REQ1_VALID = 1; REQ1_DATA = 8'hB0; tick();
    REQ0_DATA = 8'hA1; REQ1_DATA = 8'hB1; tick();
    REQ0_VALID = 0; REQ1_VALID = 0;
    TX_STATUS = 1; snd_auto = 1;
    repeat (30) tick();
    snd_auto = 0;
    exp_b[0] = 8'hB0; exp_b[1] = 8'hA0; exp_b[2] = 8'hB1; exp_b[3] = 8'hA1;
    exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1; exp_g[3] = 0;
    chk("rr_count", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_issue[%0d]", i), log_at(i), {23'd0, exp_g[i], exp_b[i]});

    // Full FIFO on port 0
    clear_log();
    TX_STATUS = 0;
    nxt = 1;
    for (int k = 0; k < 6; k++) begin
      REQ0_VALID = 1; REQ0_DATA = 8'(nxt);
      rdy = REQ0_READY;
      tick();
      if (rdy) nxt++;
    end
    chk("full_ready_low", 32'(REQ0_READY), 32'd0);
    chk("full_accepted", 32'(nxt), 32'd5);
    TX_STATUS = 1; snd_auto = 1;
    for (int k = 0; k < 40; k++) begin
      REQ0_VALID = (nxt <= 5);
      REQ0_DATA  = 8'(nxt);
      rdy = REQ0_READY;
      tick();
      if (rdy && nxt <= 5) nxt++;
    end
    REQ0_VALID = 0; snd_auto = 0;
    chk("full_count", 32'(log_d.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("full_issue[%0d]", i), 32'(log_at(i) & 32'hff), 32'(i + 1));

    // Timeout with Sender stuck idle
    clear_log();
    TX_STATUS = 1;
    REQ0_VALID = 1; REQ0_DATA = 8'h23; tick();
    REQ0_DATA = 8'h24; tick();
    REQ0_VALID = 0;
    chk("to_issue", 32'({TX_EN, TX_DATA}), 32'({1'b1, 8'h23}));
    repeat (7) tick();
    chk("to_before", 32'({TX_TIMEOUT, BUSY}), 32'b01);
    tick();
    chk("to_set", 32'({TX_TIMEOUT, BUSY}), 32'b10);
    tick();
    chk("to_next_issue", 32'({TX_EN, TX_DATA}), 32'({1'b1, 8'h24}));
    TX_STATUS = 0; repeat (3) tick();
    TX_STATUS = 1; repeat (3) tick();
    chk("to_sticky", 32'(TX_TIMEOUT), 32'd1);

    // Reset while the Sender is mid-frame
    clear_log();
    TX_STATUS = 0;
    REQ1_VALID = 1;
    REQ1_DATA = 8'hC0; tick();
    REQ1_DATA = 8'hC1; tick();
    REQ1_DATA = 8'hC2; tick();
    REQ1_VALID = 0;
    TX_STATUS = 1; tick();
    chk("rst_pre_issue", 32'({TX_EN, GRANT, TX_DATA}), 32'({2'b11, 8'hC0}));
    TX_STATUS = 0; tick(); tick();
    #2 reset = 0;
    #1 chk("rst_mid_frame", 32'(dut_vec()), 32'(ev(0, 8'h00, 0, 0, 0, 1, 1)));
    model_reset();
    clear_log();
    @(negedge sysclk);
    reset = 1;
    TX_STATUS = 1;
    repeat (10) tick();
    chk("rst_no_issue", 32'(log_d.size()), 32'd0);
    REQ0_VALID = 1; REQ0_DATA = 8'hE5; tick();
    REQ0_VALID = 0; tick();
    chk("rst_new_issue", 32'({TX_EN, TX_DATA}), 32'({1'b1, 8'hE5}));
    TX_STATUS = 0; tick();
    TX_STATUS = 1; tick();

    // Push and pop of FIFO 1 on the same edge
    clear_log();
    TX_STATUS = 0;
    REQ1_VALID = 1;
    REQ1_DATA = 8'hD0; tick();
    REQ1_DATA = 8'hD1; tick();
    TX_STATUS = 1; REQ1_DATA = 8'hD2; tick();
    chk("pp_issue", 32'({TX_EN, TX_DATA}), 32'({1'b1, 8'hD0}));
    TX_STATUS = 0; REQ1_DATA = 8'hD3; tick();
    chk("pp_ready_at3", 32'(REQ1_READY), 32'd1);
    REQ1_DATA = 8'hD4; tick();
    chk("pp_ready_at4", 32'(REQ1_READY), 32'd0);
    REQ1_VALID = 0;
    TX_STATUS = 1; snd_auto = 1;
    repeat (40) tick();
    snd_auto = 0;
    chk("pp_count", 32'(log_d.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("pp_issue[%0d]", i), 32'(log_at(i) & 32'hff), 32'(8'hD0 + i));

    // Randomized traffic against the model
    TX_STATUS = 1; snd_auto = 1; snd_rand = 1;
    for (int k = 0; k < 2500; k++) begin
      REQ0_VALID = ($urandom % 100) < 35;
      REQ0_DATA  = 8'($urandom);
      REQ1_VALID = ($urandom % 100) < 35;
      REQ1_DATA  = 8'($urandom);
      tick();
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Two-requester transmit scheduler that shares one UART `Sender` between two byte producers. Each requester pushes bytes into its own small FIFO through a valid/ready handshake. The scheduler drains the FIFOs in round-robin order, one byte at a time. For each byte it drives `TX_DATA`/`TX_EN` and uses `TX_STATUS` to track when the `Sender` has finished the frame.

## Interface
- `DEPTH`, 4, entries per requester FIFO; power of two, ≥2
- `TIMEOUT`, 8, cycles to wait for `TX_STATUS` to fall after a `TX_EN` pulse; range 1..255
- `sysclk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `REQ0_DATA`  in  8  byte from requester 0
- `REQ0_VALID`  in  1  requester 0 offers `REQ0_DATA`
- `REQ0_READY`  out  1  FIFO 0 not full
- `REQ1_DATA`  in  8  byte from requester 1
- `REQ1_VALID`  in  1  requester 1 offers `REQ1_DATA`
- `REQ1_READY`  out  1  FIFO 1 not full
- `TX_DATA`  out  8  byte to `Sender`, registered, held stable until next issue
- `TX_EN`  out  1  one-cycle start pulse to `Sender`, registered
- `TX_STATUS`  in  1  `Sender` idle (1) / transmitting (0)
- `GRANT`  out  1  requester whose byte was most recently issued
- `BUSY`  out  1  state ≠ IDLE
- `TX_TIMEOUT`  out  1  sticky: a `TX_EN` pulse was not acknowledged within `TIMEOUT` cycles

## Operation
- **Push.** On a rising edge with `REQn_VALID & REQn_READY`, `REQn_DATA` is written to FIFO n.
  - `REQn_READY` = !full_n, combinational from the count register.
  - A push into a full FIFO is never accepted, even if a pop of that FIFO happens in the same cycle.
- **FIFOs.**
  - Per FIFO: write pointer, read pointer (log2(`DEPTH`) bits, wrapping), and a count of log2(`DEPTH`)+1 bits.
  - A simultaneous push and pop leaves the count unchanged.
- **State machine:** IDLE, WAIT_LOW, WAIT_HIGH.
- **IDLE.** When `TX_STATUS`=1 and at least one FIFO is non-empty, the scheduler selects a requester:
  - If only one FIFO is non-empty, select it.
  - If both are non-empty, select the port ≠ `GRANT`. After reset `GRANT`=0, so when both FIFOs are non-empty for the first time, port 1 goes first.
  - On the same edge:
    - `TX_DATA` ← head of the selected FIFO.
    - Pop the selected FIFO.
    - `TX_EN` ← 1.
    - `GRANT` ← selected port.
    - Clear the timeout counter.
    - Go to WAIT_LOW.
  - If `TX_STATUS`=0 in IDLE, nothing is issued.
- **WAIT_LOW.**
  - `TX_EN` ← 0 on the first edge in this state.
  - If `TX_STATUS`=0 → WAIT_HIGH.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`: `TX_TIMEOUT` ← 1, → IDLE. The byte is treated as consumed and is not re-sent.
- **WAIT_HIGH.** When `TX_STATUS`=1 → IDLE; otherwise stay.
- Only one byte is ever outstanding at the `Sender`.
- `TX_TIMEOUT` clears only on reset.

## Timing
- **Reset** (`reset`=0, asynchronous):
  - `TX_EN`=0, `TX_DATA`=8'h00, `GRANT`=0, `BUSY`=0, `TX_TIMEOUT`=0.
  - State IDLE; both FIFOs empty, so `REQ0_READY`=`REQ1_READY`=1.
  - Asserting reset mid-frame drops all queued bytes and ends any `TX_EN` pulse immediately.
  - The `Sender` frame already in progress is not tracked after reset.
- **Latency.** For a byte pushed at edge k into an empty scheduler with `TX_STATUS`=1:
  - The FIFO is non-empty after edge k.
  - The issue happens at edge k+1: `TX_EN`=1 and `TX_DATA` valid for exactly one cycle (k+1 to k+2).
- **Back-to-back.** The next issue occurs on the first edge at which the state is IDLE with `TX_STATUS`=1. The minimum gap is one cycle after the edge where WAIT_HIGH sees `TX_STATUS`=1.
- **Sender response time.** The `Sender` must drop `TX_STATUS` within `TIMEOUT` cycles after the edge that set `TX_EN`.
- **`BUSY`** is registered. It is 1 from the issue edge until the return to IDLE.

## Test plan
- **Single byte.** Reset, then push 8'h35 on port 0; model `Sender` drops `TX_STATUS` 1 cycle after `TX_EN` and holds it low 10 cycles → one `TX_EN` pulse 1 cycle wide with `TX_DATA`=8'h35, `GRANT`=0, `BUSY` high until `TX_STATUS` returns high.
- **Round-robin.** Preload port 0 with 8'hA0, 8'hA1 and port 1 with 8'hB0, 8'hB1 while `TX_STATUS`=0, then release → issue order B0, A0, B1, A1; `GRANT` toggles 1, 0, 1, 0.
- **Full FIFO.** Hold `REQ0_VALID`=1 with data 8'h01..8'h06 while `TX_STATUS`=0 → 4 bytes accepted, `REQ0_READY`=0 afterward; after the first pop `READY`=1 and byte 8'h05 is accepted; the issued sequence is 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no loss or duplication.
- **Timeout.** Push 8'h23 while `TX_STATUS` is stuck at 1 → one `TX_EN` pulse, then after `TIMEOUT`=8 cycles `TX_TIMEOUT`=1 and state is IDLE; the next queued byte issues normally and `TX_TIMEOUT` stays 1.
- **Reset mid-frame.** Queue 3 bytes, assert `reset` low during WAIT_HIGH → all outputs at reset values immediately; after release no `TX_EN` occurs until a new push.
- **Simultaneous push/pop.** With FIFO 1 at count 2, push on the same edge as the pop → count stays 2; data order is preserved.
